// File: rtl/serial_nibble_subtractor_pkg.sv
// ============================================================================
// Module   : sub_pkg
// Brief    : Shared types and constants for the serial nibble subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : sub_pkg

`default_nettype wire

// File: rtl/nibble_sub_4_bit.sv
// ============================================================================
// Module   : nibble_sub_4_bit
// Brief    : Combinational 4-bit ripple subtract slice (full adders, in2 inverted).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_sub_4_bit
    import sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] in1,
    input  logic [NIBBLE_W-1:0] in2,
    input  logic                b_in,
    output logic [NIBBLE_W-1:0] diff,
    output logic                b_out,
    output logic                c3
);

    // Carry chain of a + ~b + ~borrow; a borrow is the inverse of a carry.
    logic [NIBBLE_W:0] w_c;

    assign w_c[0] = ~b_in;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        logic w_inv_b;
        assign w_inv_b    = ~in2[i];
        assign diff[i]    = in1[i] ^ w_inv_b ^ w_c[i];
        assign w_c[i + 1] = (in1[i] & w_inv_b) | (w_c[i] & (in1[i] ^ w_inv_b));
    end

    assign b_out = ~w_c[NIBBLE_W];
    assign c3    = w_c[NIBBLE_W - 1];

endmodule : nibble_sub_4_bit

`default_nettype wire

// File: rtl/serial_nibble_subtractor.sv
// ============================================================================
// Module   : serial_nibble_subtractor
// Brief    : WIDTH-bit subtractor computing one nibble per clock, valid/ready I/O.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_nibble_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t               state_q;
    state_t               state_d;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     diff_q;
    logic                 borrow_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 out_valid_q;
    logic                 b_out_q;
    logic                 overflow_q;

    logic [NIBBLE_W-1:0]  w_nib_a;
    logic [NIBBLE_W-1:0]  w_nib_b;
    logic [NIBBLE_W-1:0]  w_nib_d;
    logic                 w_nib_bout;
    logic                 w_nib_c3;
    logic                 w_last;

    assign w_nib_a = a_q[idx_q * NIBBLE_W +: NIBBLE_W];
    assign w_nib_b = b_q[idx_q * NIBBLE_W +: NIBBLE_W];
    assign w_last  = (idx_q == IDX_W'(NIBBLES - 1));

    nibble_sub_4_bit u_slice (
        .in1   (w_nib_a),
        .in2   (w_nib_b),
        .b_in  (borrow_q),
        .diff  (w_nib_d),
        .b_out (w_nib_bout),
        .c3    (w_nib_c3)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_valid) state_d = RUN;
            RUN:     if (w_last)      state_d = DONE;
            DONE:    if (out_ready)   state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            b_out_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_q      <= in1;
                        b_q      <= in2;
                        borrow_q <= b_in;
                        idx_q    <= '0;
                    end
                end
                RUN: begin
                    diff_q[idx_q * NIBBLE_W +: NIBBLE_W] <= w_nib_d;
                    borrow_q <= w_nib_bout;
                    idx_q    <= idx_q + IDX_W'(1);
                    if (w_last) begin
                        // Carry-out of the top nibble is the inverse of its borrow-out.
                        b_out_q     <= w_nib_bout;
                        overflow_q  <= w_nib_c3 ^ ~w_nib_bout;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign start_ready = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign diff        = diff_q;
    assign b_out       = b_out_q;
    assign overflow    = overflow_q;

endmodule : serial_nibble_subtractor

`default_nettype wire
